// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the CPU stack controller: data width, op encoding, capacity helper.
// Pure declarations; no timing or flow control involved.
package stack_ctrl_pkg;

  localparam int WIDTH = 16;

  // {push, pop} encoding, also used by the core's decoder
  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Elements held in total: every spill-memory entry plus the TOS register
  function automatic int stack_cap(input int depth);
    return (2 ** depth) + 1;
  endfunction

endpackage

// File: rtl/stack.sv
// Spill register file: combinational read port, synchronous write port, contents not reset.
// Write lands on the rising edge and is visible on rd immediately after; never stalls.
module stack
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic [DEPTH-1:0] ra,
  output logic [WIDTH-1:0] rd,
  input  logic             we,
  input  logic [DEPTH-1:0] wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] mem [2**DEPTH];

  assign rd = mem[ra];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: TOS in a register, lower entries spilled to a stack memory, sticky errors.
// Single-cycle push/pop/replace every clock; no handshake, illegal ops only set error flags.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DEPTH-1:0] sp,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [DEPTH:0] CNT_ONE = {{DEPTH{1'b0}}, 1'b1};
  localparam logic [DEPTH:0] CNT_CAP = {1'b1, {DEPTH{1'b0}}} + CNT_ONE;

  logic [1:0]       op;
  logic [WIDTH-1:0] mem_rd;
  logic [DEPTH-1:0] sp_inc;
  logic [DEPTH-1:0] sp_dec;
  logic             spill;
  logic             ovf_set;
  logic             unf_set;
  logic             multi;

  assign op     = {push, pop};
  assign sp_inc = sp + 1'b1;
  assign sp_dec = sp - 1'b1;
  assign empty  = (count == '0);
  assign full   = (count == CNT_CAP);
  assign multi  = (count > CNT_ONE);

  // Replace never counts as an attempted push/pop for error purposes
  always_comb begin
    spill   = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        spill   = !empty && !full;
        ovf_set = full;
      end
      OP_POP: begin
        unf_set = empty;
      end
      default: begin
      end
    endcase
  end

  assign nos = multi ? mem_rd : '0;

  stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk (clk),
    .ra  (sp),
    .rd  (mem_rd),
    .we  (spill),
    .wa  (sp_inc),
    .wd  (tos)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tos       <= '0;
      sp        <= '1;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A fresh error in the same cycle as clr_err keeps its flag set
      overflow  <= (overflow  & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | unf_set;
      case (op)
        OP_PUSH, OP_REPL: begin
          if (empty) begin
            tos   <= din;
            count <= CNT_ONE;
          end else if (op == OP_REPL) begin
            tos <= din;
          end else if (!full) begin
            tos   <= din;
            sp    <= sp_inc;
            count <= count + CNT_ONE;
          end
        end
        OP_POP: begin
          if (multi) begin
            tos   <= mem_rd;
            sp    <= sp_dec;
            count <= count - CNT_ONE;
          end else if (!empty) begin
            tos   <= '0;
            count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a queue-based stack model predicts every cycle's outputs.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CAP   = (2 ** DEPTH) + 1;

  typedef struct {
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [DEPTH-1:0] sp;
    logic [DEPTH:0]   count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
  } exp_t;

  logic             clk;
  logic             resetq;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [DEPTH-1:0] sp;
  logic [DEPTH:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_stk [$];
  logic             m_ovf;
  logic             m_unf;
  exp_t             exp_q [$];

  stack_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetq    (resetq),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .clr_err   (clr_err),
    .tos       (tos),
    .nos       (nos),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs derived from the model stack contents alone
  function automatic exp_t snap();
    exp_t e;
    int n;
    n       = m_stk.size();
    e.count = (DEPTH+1)'(n);
    e.tos   = (n >= 1) ? m_stk[n-1] : '0;
    e.nos   = (n >= 2) ? m_stk[n-2] : '0;
    e.sp    = (n == 0) ? '1 : DEPTH'(n - 2);
    e.empty = (n == 0);
    e.full  = (n == CAP);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    logic ovf_new;
    logic unf_new;
    ovf_new = 1'b0;
    unf_new = 1'b0;
    if (p && q) begin
      if (m_stk.size() == 0) m_stk.push_back(d);
      else m_stk[m_stk.size()-1] = d;
    end else if (p) begin
      if (m_stk.size() == CAP) ovf_new = 1'b1;
      else m_stk.push_back(d);
    end else if (q) begin
      if (m_stk.size() == 0) unf_new = 1'b1;
      else void'(m_stk.pop_back());
    end
    m_ovf = (m_ovf && !c) || ovf_new;
    m_unf = (m_unf && !c) || unf_new;
  endtask

  task automatic do_op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    push    = p;
    pop     = q;
    din     = d;
    clr_err = c;
    model_step(p, q, d, c);
    exp_q.push_back(snap());
  endtask

  task automatic reset_mid();
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.push_back(snap());
    #2;
    resetq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares after every clock edge or async reset for which a prediction exists
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge resetq);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tos",       32'(tos),       32'(e.tos));
        chk("nos",       32'(nos),       32'(e.nos));
        chk("sp",        32'(sp),        32'(e.sp));
        chk("count",     32'(count),     32'(e.count));
        chk("empty",     32'(empty),     32'(e.empty));
        chk("full",      32'(full),      32'(e.full));
        chk("overflow",  32'(overflow),  32'(e.ovf));
        chk("underflow", 32'(underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    int r;
    resetq  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = '0;
    clr_err = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    repeat (2) @(negedge clk);
    resetq = 1'b1;

    repeat (3) do_op(1'b0, 1'b0, '0, 1'b0);

    for (int i = 1; i <= 3; i++) do_op(1'b1, 1'b0, WIDTH'(i), 1'b0);
    repeat (3) do_op(1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i <= 16; i++) do_op(1'b1, 1'b0, WIDTH'(i), 1'b0);
    do_op(1'b1, 1'b0, WIDTH'(99), 1'b0);
    do_op(1'b0, 1'b0, '0, 1'b1);
    repeat (CAP) do_op(1'b0, 1'b1, '0, 1'b0);

    do_op(1'b0, 1'b1, '0, 1'b0);
    do_op(1'b0, 1'b1, '0, 1'b1);
    do_op(1'b0, 1'b0, '0, 1'b1);

    do_op(1'b1, 1'b0, WIDTH'(5), 1'b0);
    do_op(1'b1, 1'b0, WIDTH'(9), 1'b0);
    do_op(1'b1, 1'b1, WIDTH'(7), 1'b0);
    repeat (2) do_op(1'b0, 1'b1, '0, 1'b0);
    do_op(1'b1, 1'b1, WIDTH'(4), 1'b0);
    do_op(1'b0, 1'b1, '0, 1'b0);

    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, WIDTH'(20 + i), 1'b0);
    reset_mid();
    do_op(1'b1, 1'b0, WIDTH'(8), 1'b0);
    do_op(1'b0, 1'b0, '0, 1'b0);

    // Random phases: push-heavy to reach full/wrap, then pop-heavy to drain past empty
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (i < 300) begin
        if (r < 55)      do_op(1'b1, 1'b0, WIDTH'($urandom), ($urandom_range(0, 19) == 0));
        else if (r < 80) do_op(1'b0, 1'b1, '0, ($urandom_range(0, 19) == 0));
        else if (r < 90) do_op(1'b1, 1'b1, WIDTH'($urandom), ($urandom_range(0, 19) == 0));
        else             do_op(1'b0, 1'b0, '0, ($urandom_range(0, 19) == 0));
      end else begin
        if (r < 30)      do_op(1'b1, 1'b0, WIDTH'($urandom), ($urandom_range(0, 19) == 0));
        else if (r < 80) do_op(1'b0, 1'b1, '0, ($urandom_range(0, 19) == 0));
        else if (r < 90) do_op(1'b1, 1'b1, WIDTH'($urandom), ($urandom_range(0, 19) == 0));
        else             do_op(1'b0, 1'b0, '0, ($urandom_range(0, 19) == 0));
      end
    end
    do_op(1'b0, 1'b0, '0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
